// File: rtl/wb_commit_queue_if.sv
// Writeback commit queue bus: execute-side result slots in, register-file write ports out.
// The master modport is the producer/observer side; the slave modport is the queue itself.
interface wb_commit_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                     in_valid_1;
  logic [4:0]               in_idx_1;
  logic [XLEN-1:0]          in_data_1;
  logic                     in_valid_2;
  logic [4:0]               in_idx_2;
  logic [XLEN-1:0]          in_data_2;
  logic                     in_ready;
  logic                     wb_stall;
  logic                     write_en_1;
  logic [4:0]               write_idx_1;
  logic [XLEN-1:0]          write_data_1;
  logic                     write_en_2;
  logic [4:0]               write_idx_2;
  logic [XLEN-1:0]          write_data_2;
  logic [$clog2(DEPTH):0]   occupancy;
  logic [31:0]              retire_count;

  modport master (
    output in_valid_1, in_idx_1, in_data_1,
    output in_valid_2, in_idx_2, in_data_2,
    output wb_stall,
    input  in_ready,
    input  write_en_1, write_idx_1, write_data_1,
    input  write_en_2, write_idx_2, write_data_2,
    input  occupancy, retire_count
  );

  modport slave (
    input  in_valid_1, in_idx_1, in_data_1,
    input  in_valid_2, in_idx_2, in_data_2,
    input  wb_stall,
    output in_ready,
    output write_en_1, write_idx_1, write_data_1,
    output write_en_2, write_idx_2, write_data_2,
    output occupancy, retire_count
  );
endinterface

// File: rtl/wb_commit_queue.sv
// In-order two-wide writeback commit FIFO with same-destination cancellation on each drain beat.
// Optional same-cycle bypass when empty is enabled by defining WB_COMMIT_BYPASS_EN.
module wb_commit_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic           clock,
  input logic           reset,
  wb_commit_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  typedef struct packed {
    logic [4:0]      idx;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [OW-1:0]   occ_q;
  logic [31:0]     retire_q;

  entry_t          slot_1;
  entry_t          slot_2;
  entry_t          port_1;
  entry_t          port_2;
  logic            keep_1;
  logic            keep_2;
  logic            ready;
  logic            bypass;
  logic            accept;
  logic            en_1;
  logic            en_2;
  logic [1:0]      enq_n;
  logic [1:0]      pop_n;
  logic [1:0]      drained_n;

  assign slot_1 = {bus.in_idx_1, bus.in_data_1};
  assign slot_2 = {bus.in_idx_2, bus.in_data_2};

  // Writes to x0 are architecturally dead, so they never take a queue entry.
  assign keep_1 = bus.in_valid_1 && (bus.in_idx_1 != 5'd0);
  assign keep_2 = bus.in_valid_2 && (bus.in_idx_2 != 5'd0);

  assign ready  = (occ_q <= OW'(DEPTH - 2));

`ifdef WB_COMMIT_BYPASS_EN
  assign bypass = !reset && (occ_q == '0) && !bus.wb_stall && ready;
`else
  assign bypass = 1'b0;
`endif

  assign accept = ready && !bypass && !reset;
  assign enq_n  = accept ? ({1'b0, keep_1} + {1'b0, keep_2}) : 2'd0;

  always_comb begin
    port_1    = '0;
    port_2    = '0;
    en_1      = 1'b0;
    en_2      = 1'b0;
    pop_n     = 2'd0;
    drained_n = 2'd0;
    if (bypass) begin
      if (keep_1) begin
        port_1 = slot_1;
        en_1   = 1'b1;
        if (keep_2) begin
          port_2 = slot_2;
          en_2   = 1'b1;
        end
      end else if (keep_2) begin
        port_1 = slot_2;
        en_1   = 1'b1;
      end
      drained_n = {1'b0, keep_1} + {1'b0, keep_2};
    end else if (!reset && !bus.wb_stall && (occ_q != '0)) begin
      port_1 = mem_q[head_q];
      en_1   = 1'b1;
      pop_n  = 2'd1;
      if (occ_q >= OW'(2)) begin
        port_2 = mem_q[head_q + PW'(1)];
        en_2   = 1'b1;
        pop_n  = 2'd2;
      end
      drained_n = pop_n;
    end
    // The younger write wins; the older one is dropped but still counts as retired.
    if (en_1 && en_2 && (port_1.idx == port_2.idx)) begin
      en_1   = 1'b0;
      port_1 = '0;
    end
  end

  assign bus.in_ready     = ready;
  assign bus.write_en_1   = en_1;
  assign bus.write_idx_1  = port_1.idx;
  assign bus.write_data_1 = port_1.data;
  assign bus.write_en_2   = en_2;
  assign bus.write_idx_2  = port_2.idx;
  assign bus.write_data_2 = port_2.data;
  assign bus.occupancy    = occ_q;
  assign bus.retire_count = retire_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      occ_q    <= '0;
      retire_q <= '0;
    end else begin
      head_q   <= head_q + PW'(pop_n);
      tail_q   <= tail_q + PW'(enq_n);
      occ_q    <= occ_q + OW'(enq_n) - OW'(pop_n);
      retire_q <= retire_q + 32'(drained_n);
    end
  end

  // A lone slot 2 lands at the tail itself; after a kept slot 1 it lands one past it.
  always_ff @(posedge clock) begin
    if (accept) begin
      if (keep_1) begin
        mem_q[tail_q] <= slot_1;
      end
      if (keep_2) begin
        mem_q[tail_q + PW'(keep_1)] <= slot_2;
      end
    end
  end
endmodule

// File: tb/tb_wb_commit_queue.sv
// Scoreboard bench for wb_commit_queue: a queue-based reference model predicts each write beat,
// and a negedge monitor compares the DUT write ports against those predictions.
module tb_wb_commit_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]      idx;
    logic [XLEN-1:0] data;
  } m_entry_t;

  typedef struct {
    bit              en1;
    logic [4:0]      idx1;
    logic [XLEN-1:0] data1;
    bit              cancel1;
    bit              en2;
    logic [4:0]      idx2;
    logic [XLEN-1:0] data2;
  } beat_t;

  logic clock;
  logic reset;

  wb_commit_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  wb_commit_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  m_entry_t    model_q [$];
  beat_t       exp_beats [$];
  int unsigned model_retire;
  bit          model_valid;
  bit          running;
  int          n_cmp;
  int          n_fail;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour for one clock cycle: drain from the pre-enqueue queue, then append accepted slots.
  task automatic model_step(input bit v1, input logic [4:0] i1, input logic [XLEN-1:0] d1,
                            input bit v2, input logic [4:0] i2, input logic [XLEN-1:0] d2,
                            input bit stall, input bit rst);
    beat_t    b;
    m_entry_t kept [$];
    m_entry_t popped [$];
    bit       rdy;
    bit       byp;
    b = '{default: '0};
    if (rst) begin
      model_q.delete();
      model_retire = 0;
      exp_beats.push_back(b);
      return;
    end
    rdy = (DEPTH - model_q.size()) >= 2;
    if (v1 && i1 != 5'd0) kept.push_back('{idx: i1, data: d1});
    if (v2 && i2 != 5'd0) kept.push_back('{idx: i2, data: d2});
    byp = 1'b0;
`ifdef WB_COMMIT_BYPASS_EN
    byp = (model_q.size() == 0) && !stall && rdy;
`endif
    if (byp) begin
      popped = kept;
    end else if (!stall) begin
      for (int k = 0; k < 2; k++) begin
        if (model_q.size() > 0) popped.push_back(model_q.pop_front());
      end
    end
    if (!byp && rdy) begin
      foreach (kept[k]) model_q.push_back(kept[k]);
    end
    model_retire += popped.size();
    if (popped.size() >= 1) begin
      b.en1   = 1'b1;
      b.idx1  = popped[0].idx;
      b.data1 = popped[0].data;
    end
    if (popped.size() == 2) begin
      b.en2   = 1'b1;
      b.idx2  = popped[1].idx;
      b.data2 = popped[1].data;
      if (popped[0].idx == popped[1].idx) begin
        b.en1     = 1'b0;
        b.cancel1 = 1'b1;
      end
    end
    exp_beats.push_back(b);
  endtask

  task automatic applyStimulus(input bit v1, input logic [4:0] i1, input logic [XLEN-1:0] d1,
                               input bit v2, input logic [4:0] i2, input logic [XLEN-1:0] d2,
                               input bit stall, input bit rst);
    @(posedge clock);
    #1;
    if (model_valid) begin
      checkOutput("occupancy", bus.occupancy, model_q.size());
      checkOutput("in_ready", bus.in_ready, ((DEPTH - model_q.size()) >= 2) ? 1 : 0);
      checkOutput("retire_count", bus.retire_count, model_retire);
    end
    reset          = rst;
    bus.in_valid_1 = v1;
    bus.in_idx_1   = i1;
    bus.in_data_1  = d1;
    bus.in_valid_2 = v2;
    bus.in_idx_2   = i2;
    bus.in_data_2  = d2;
    bus.wb_stall   = stall;
    model_step(v1, i1, d1, v2, i2, d2, stall, rst);
    if (rst) model_valid = 1'b1;
  endtask

  task automatic idle(input bit stall);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, stall, 1'b0);
  endtask

  // Write-port monitor: one predicted beat per cycle, compared mid-cycle.
  initial begin
    beat_t b;
    forever begin
      @(negedge clock);
      if (running) begin
        if (exp_beats.size() == 0) begin
          checkOutput("unexpected_write", {bus.write_en_1, bus.write_en_2}, 0);
        end else begin
          b = exp_beats.pop_front();
          checkOutput("write_en_1", bus.write_en_1, b.en1);
          checkOutput("write_en_2", bus.write_en_2, b.en2);
          if (!b.cancel1) begin
            checkOutput("write_idx_1", bus.write_idx_1, b.idx1);
            checkOutput("write_data_1", bus.write_data_1, b.data1);
          end
          checkOutput("write_idx_2", bus.write_idx_2, b.idx2);
          checkOutput("write_data_2", bus.write_data_2, b.data2);
        end
      end
    end
  end

  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    model_retire   = 0;
    model_valid    = 1'b0;
    running        = 1'b1;
    reset          = 1'b1;
    bus.in_valid_1 = 1'b0;
    bus.in_idx_1   = '0;
    bus.in_data_1  = '0;
    bus.in_valid_2 = 1'b0;
    bus.in_idx_2   = '0;
    bus.in_data_2  = '0;
    bus.wb_stall   = 1'b0;

    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 1'b1);
    idle(1'b0);
    checkOutput("reset_occupancy", bus.occupancy, 0);
    checkOutput("reset_in_ready", bus.in_ready, 1);
    checkOutput("reset_retire", bus.retire_count, 0);

    $display("[TB] ordered pair, collision, x0 filter");
    applyStimulus(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    checkOutput("pair_retire", bus.retire_count, 2);
    applyStimulus(1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB, 1'b0, 1'b0);
    idle(1'b0);
    applyStimulus(1'b1, 5'd0, 32'hFF, 1'b1, 5'd3, 32'h33, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    $display("[TB] fill and backpressure");
    applyStimulus(1'b1, 5'd8,  32'h80, 1'b1, 5'd9,  32'h90, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0, 1'b1, 1'b0);
    checkOutput("full_occupancy", bus.occupancy, 4);
    checkOutput("full_in_ready", bus.in_ready, 0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    $display("[TB] streaming across the wrap");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 5'(1 + 2 * i), 32'h1000 + i, 1'b1, 5'(2 + 2 * i), 32'h2000 + i,
                    (i % 3) == 1, 1'b0);
    end
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    $display("[TB] reset with three entries held");
    applyStimulus(1'b1, 5'd20, 32'h200, 1'b1, 5'd21, 32'h210, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd22, 32'h220, 1'b0, 5'd0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 1'b1);
    checkOutput("pre_reset_occupancy", bus.occupancy, 3);
    idle(1'b0);
    checkOutput("post_reset_occupancy", bus.occupancy, 0);
    checkOutput("post_reset_retire", bus.retire_count, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 9) < 3, $urandom_range(0, 99) == 0);
    end
    for (int i = 0; i < 4; i++) idle(1'b0);

    @(negedge clock);
    #1;
    running = 1'b0;
    checkOutput("beats_drained", exp_beats.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
